// File: rtl/demux_1to4_32.sv
// Registered 1-to-4 demultiplexer for 32-bit words with one holding register per output port.
// Optional feature macro: DEMUX_STATS_EN enables the accepted-word counter on xfer_count.
module demux_1to4_32 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic [31:0]      in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic [31:0]      out_c,
    output logic [31:0]      out_d,
    output logic [CNT_W-1:0] xfer_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } port_state_t;

    logic        accept;
    logic [31:0] data_arr [4];

    // A full port can still take a word in the same cycle its consumer drains it.
    assign in_ready = !out_valid[sel] | out_ready[sel];
    assign accept   = in_valid & in_ready;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_port
            port_state_t state_q, state_d;
            logic [31:0] data_q, data_d;
            logic        load;

            assign load = accept & (sel == 2'(gi));

            always_comb begin
                state_d = state_q;
                data_d  = data_q;
                case (state_q)
                    EMPTY: begin
                        if (load) state_d = FULL;
                    end
                    FULL: begin
                        if (!load && out_ready[gi]) state_d = EMPTY;
                    end
                    default: state_d = EMPTY;
                endcase
                if (load) data_d = in_data;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= EMPTY;
                    data_q  <= 32'h0;
                end else begin
                    state_q <= state_d;
                    data_q  <= data_d;
                end
            end

            assign out_valid[gi] = (state_q == FULL);
            assign data_arr[gi]  = data_q;
        end
    endgenerate

    assign out_a = data_arr[0];
    assign out_b = data_arr[1];
    assign out_c = data_arr[2];
    assign out_d = data_arr[3];

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign xfer_count = cnt_q;
`else
    assign xfer_count = '0;
`endif

endmodule

// File: tb/tb_demux_1to4_32.sv
// Directed self-checking bench for demux_1to4_32: reset, routing, back-pressure,
// round robin, same-port back-to-back, asynchronous reset and the transfer counter.
module tb_demux_1to4_32;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       sel;
    logic [31:0]      in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [31:0]      out_a, out_b, out_c, out_d;
    logic [CNT_W-1:0] xfer_count;

    int n_checks = 0;
    int n_fail   = 0;

    demux_1to4_32 #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_c      (out_c),
        .out_d      (out_d),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] port_data(input int k);
        case (k)
            0:       return out_a;
            1:       return out_b;
            2:       return out_c;
            default: return out_d;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; sel = 2'd0; in_data = 32'h0; out_ready = 4'b0000;
        step(); step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got=%b exp=0000", out_valid); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (port_data(k) !== 32'h0) begin n_fail++; $display("FAIL reset_data port=%0d got=%h exp=0", k, port_data(k)); end
            sel = 2'(k);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready sel=%0d got=%b exp=1", k, in_ready); end
        end
        n_checks++;
        if (xfer_count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", xfer_count); end
        step();
    endtask

    task automatic test_simple_route();
        in_valid = 1'b1; sel = 2'd2; in_data = 32'hDEADBEEF; out_ready = 4'b0000;
        step();
        in_valid = 1'b0;
        $display("xfer sel=2 data=deadbeef");
        n_checks++;
        if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL route_valid got=%b exp=0100", out_valid); end
        n_checks++;
        if (out_c !== 32'hDEADBEEF) begin n_fail++; $display("FAIL route_c got=%h exp=deadbeef", out_c); end
        n_checks++;
        if ({out_a, out_b, out_d} !== 96'h0) begin n_fail++; $display("FAIL route_others got=%h/%h/%h exp=0", out_a, out_b, out_d); end
        in_valid = 1'b1; sel = 2'd2; in_data = 32'h00000001;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL route_full_in_ready got=%b exp=0", in_ready); end
        step();
        n_checks++;
        if (out_c !== 32'hDEADBEEF) begin n_fail++; $display("FAIL route_stall_hold got=%h exp=deadbeef", out_c); end
    endtask

    task automatic test_backpressure_release();
        out_ready = 4'b0100;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        $display("xfer sel=2 data=00000001");
        n_checks++;
        if (out_c !== 32'h00000001 || out_valid !== 4'b0100) begin
            n_fail++; $display("FAIL bp_replace got=%h/%b exp=00000001/0100", out_c, out_valid);
        end
        step();
        n_checks++;
        if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_drain got=%b exp=0000", out_valid); end
        n_checks++;
        if (out_c !== 32'h00000001) begin n_fail++; $display("FAIL bp_data_hold got=%h exp=00000001", out_c); end
    endtask

    task automatic test_round_robin();
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; sel = 2'(k); in_data = 32'(k + 1);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rr_in_ready k=%0d got=%b exp=1", k, in_ready); end
            step();
            $display("xfer sel=%0d data=%h", k, 32'(k + 1));
            n_checks++;
            if (out_valid !== 4'(1 << k)) begin n_fail++; $display("FAIL rr_valid k=%0d got=%b exp=%b", k, out_valid, 4'(1 << k)); end
            n_checks++;
            if (port_data(k) !== 32'(k + 1)) begin n_fail++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, port_data(k), 32'(k + 1)); end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL rr_idle got=%b exp=0000", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        words[0] = 32'hA5A5_0001; words[1] = 32'h5A5A_0002; words[2] = 32'hFFFF_0003;
        out_ready = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; sel = 2'd0; in_data = words[k];
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready k=%0d got=%b exp=1", k, in_ready); end
            step();
            $display("xfer sel=0 data=%h", words[k]);
            n_checks++;
            if (out_a !== words[k] || out_valid !== 4'b0001) begin
                n_fail++; $display("FAIL b2b_word k=%0d got=%h/%b exp=%h/0001", k, out_a, out_valid, words[k]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        logic [1:0] ports [3];
        ports[0] = 2'd0; ports[1] = 2'd1; ports[2] = 2'd3;
        out_ready = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; sel = ports[k]; in_data = 32'h1000 + 32'(k);
            step();
            $display("xfer sel=%0d data=%h", ports[k], 32'h1000 + 32'(k));
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 4'b1011) begin n_fail++; $display("FAIL ar_preload got=%b exp=1011", out_valid); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL ar_valid got=%b exp=0000", out_valid); end
        n_checks++;
        if ({out_a, out_b, out_c, out_d} !== 128'h0) begin
            n_fail++; $display("FAIL ar_data got=%h/%h/%h/%h exp=0", out_a, out_b, out_c, out_d);
        end
        n_checks++;
        if (xfer_count !== '0) begin n_fail++; $display("FAIL ar_count got=%0d exp=0", xfer_count); end
        #1 rst = 1'b0;
        step();
    endtask

    task automatic test_counter();
        logic [CNT_W-1:0] exp15, exp17;
`ifdef DEMUX_STATS_EN
        exp15 = 4'd15; exp17 = 4'd1;
`else
        exp15 = 4'd0;  exp17 = 4'd0;
`endif
        out_ready = 4'b1111;
        for (int k = 0; k < 17; k++) begin
            in_valid = 1'b1; sel = 2'(k % 4); in_data = 32'h2000 + 32'(k);
            step();
            $display("xfer sel=%0d data=%h count=%0d", k % 4, 32'h2000 + 32'(k), xfer_count);
            if (k == 0) begin
                n_checks++;
                if (out_valid !== 4'b0001 || out_a !== 32'h2000) begin
                    n_fail++; $display("FAIL cnt_first_accept got=%b/%h exp=0001/00002000", out_valid, out_a);
                end
            end
            if (k == 14) begin
                n_checks++;
                if (xfer_count !== exp15) begin n_fail++; $display("FAIL cnt_15 got=%0d exp=%0d", xfer_count, exp15); end
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (xfer_count !== exp17) begin n_fail++; $display("FAIL cnt_wrap got=%0d exp=%0d", xfer_count, exp17); end
    endtask

    initial begin
        test_reset();
        test_simple_route();
        test_backpressure_release();
        test_round_robin();
        test_back_to_back();
        test_async_reset();
        test_counter();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
